// File: rtl/residual_gen_4x4.sv
// 4x4 residual generator: subtracts prediction from original one row per cycle,
// saturates each residual and holds the full block under a valid/ready handshake.
module residual_gen_4x4 #(
    parameter int PIX_WIDTH = 8,
    parameter int RES_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          row_valid,
    output logic                          row_ready,
    input  logic [3:0][PIX_WIDTH-1:0]     orig_row,
    input  logic [3:0][PIX_WIDTH-1:0]     pred_row,
    output logic                          block_valid,
    input  logic                          block_ready,
    output logic [15:0][RES_WIDTH-1:0]    residuals,
    output logic                          sat_flag
);

    localparam int CW = (PIX_WIDTH + 1 > RES_WIDTH) ? PIX_WIDTH + 1 : RES_WIDTH;
    localparam logic signed [CW-1:0] RES_MAX =
        CW'((64'sd1 <<< (RES_WIDTH - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] RES_MIN =
        CW'(-(64'sd1 <<< (RES_WIDTH - 1)));

    typedef enum logic {FILL, FULL} state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  row_cnt_q, row_cnt_d;
    logic                        acc_q, acc_d;
    logic                        sat_q;
    logic [15:0][RES_WIDTH-1:0]  res_q;
    logic [3:0][RES_WIDTH-1:0]   row_res;
    logic [3:0]                  row_sat;
    logic                        accept;
    logic                        xfer;

    // Difference at PIX_WIDTH+1 bits, widened before clamping.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic signed [PIX_WIDTH:0] diff;
        logic signed [CW-1:0]      dx;
        assign diff = $signed({1'b0, orig_row[c]}) - $signed({1'b0, pred_row[c]});
        assign dx   = CW'(diff);
        assign row_sat[c] = (dx > RES_MAX) || (dx < RES_MIN);
        assign row_res[c] = (dx > RES_MAX) ? RES_MAX[RES_WIDTH-1:0] :
                            (dx < RES_MIN) ? RES_MIN[RES_WIDTH-1:0] :
                                             dx[RES_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FILL;
            row_cnt_q <= 2'd0;
            acc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            acc_q     <= acc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        acc_d     = acc_q;
        if (flush && state_q == FILL) begin
            row_cnt_d = 2'd0;
            acc_d     = 1'b0;
        end
        if (xfer) begin
            state_d = FILL;
        end
        if (accept) begin
            row_cnt_d = row_cnt_q + 2'd1;
            acc_d     = (row_cnt_q == 2'd0) ? (|row_sat) : (acc_q | (|row_sat));
            if (row_cnt_q == 2'd3) begin
                state_d = FULL;
            end
        end
    end

    always_comb begin
        row_ready   = !flush && (state_q == FILL || block_ready);
        block_valid = (state_q == FULL);
        accept      = row_valid && row_ready;
        xfer        = block_valid && block_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q <= '0;
            sat_q <= 1'b0;
        end else if (accept) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (row_cnt_q == 2'(r)) begin
                        res_q[4*r+c] <= row_res[c];
                    end
                end
            end
            if (row_cnt_q == 2'd3) begin
                sat_q <= acc_d;
            end
        end
    end

    assign residuals = res_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_residual_gen_4x4.sv
// Scoreboard bench for residual_gen_4x4: directed rows, expected blocks queued,
// a negedge monitor pops and compares on every block handshake.
module tb_residual_gen_4x4;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               row_valid;
    logic               row_ready;
    logic [3:0][7:0]    orig_row;
    logic [3:0][7:0]    pred_row;
    logic               block_valid;
    logic               block_ready;
    logic [15:0][7:0]   residuals;
    logic               sat_flag;

    always #5 clk = ~clk;

    residual_gen_4x4 #(.PIX_WIDTH(8), .RES_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .orig_row    (orig_row),
        .pred_row    (pred_row),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .residuals   (residuals),
        .sat_flag    (sat_flag)
    );

    typedef struct packed {
        logic [15:0][7:0] res;
        logic             sat;
    } blk_t;

    blk_t exp_q[$];
    blk_t cur;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    function automatic logic [3:0][7:0] row4(input logic [7:0] a0, a1, a2, a3);
        logic [3:0][7:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic set_exp(input int r, input logic [3:0][7:0] v);
        for (int c = 0; c < 4; c++) cur.res[4*r+c] = v[c];
    endtask

    always @(negedge clk) begin : monitor
        blk_t e;
        if (reset && block_valid && block_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL blk_unexpected: got %h expected no block", residuals);
            end else begin
                e = exp_q.pop_front();
                chk("blk_res", residuals, e.res);
                chk("blk_sat", sat_flag, e.sat);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_row(input logic [3:0][7:0] o, input logic [3:0][7:0] p);
        bit done;
        bit rdy;
        int n;
        done = 0;
        n = 0;
        row_valid = 1'b1;
        orig_row  = o;
        pred_row  = p;
        while (!done && n < 20) begin
            @(negedge clk);
            rdy = row_ready;
            @(posedge clk);
            #1;
            done = rdy;
            n++;
        end
        row_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL row_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int c0;
        reset = 1'b0; flush = 1'b0; row_valid = 1'b0; block_ready = 1'b0;
        orig_row = '0; pred_row = '0;
        #12;
        chk("rst_valid", block_valid, 0);
        chk("rst_res", residuals, 0);
        chk("rst_sat", sat_flag, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_row_ready", row_ready, 1);

        // basic block
        block_ready = 1'b1;
        cur.sat = 0;
        for (int r = 0; r < 4; r++) set_exp(r, row4(10, 9, 8, 7));
        exp_q.push_back(cur);
        for (int r = 0; r < 3; r++) put_row(row4(100, 100, 100, 100), row4(90, 91, 92, 93));
        chk("lat_before", block_valid, 0);
        put_row(row4(100, 100, 100, 100), row4(90, 91, 92, 93));
        chk("lat_valid", block_valid, 1);
        chk("lat_res", residuals, cur.res);
        idle(2);

        // saturation block
        cur.sat = 1;
        set_exp(0, row4(0, 0, 0, 0));
        set_exp(1, row4(0, 0, 0, 0));
        set_exp(2, row4(127, 8'h80, 0, 1));
        set_exp(3, row4(0, 0, 0, 0));
        exp_q.push_back(cur);
        put_row(row4(5, 5, 5, 5), row4(5, 5, 5, 5));
        put_row(row4(5, 5, 5, 5), row4(5, 5, 5, 5));
        put_row(row4(255, 0, 128, 128), row4(0, 255, 128, 127));
        put_row(row4(5, 5, 5, 5), row4(5, 5, 5, 5));
        chk("sat_set", sat_flag, 1);
        idle(1);

        // clean block with exact-limit residuals
        cur.sat = 0;
        for (int r = 0; r < 3; r++) set_exp(r, row4(10, 20, 30, 40));
        set_exp(3, row4(127, 8'h80, 0, 8'hF6));
        exp_q.push_back(cur);
        for (int r = 0; r < 3; r++) put_row(row4(20, 30, 40, 50), row4(10, 10, 10, 10));
        put_row(row4(127, 0, 0, 10), row4(0, 128, 0, 20));
        chk("sat_clear", sat_flag, 0);
        idle(2);

        // backpressure
        block_ready = 1'b0;
        cur.sat = 0;
        for (int r = 0; r < 4; r++) set_exp(r, row4(100, 50, 10, 1));
        exp_q.push_back(cur);
        for (int r = 0; r < 4; r++) put_row(row4(200, 200, 200, 200), row4(100, 150, 190, 199));
        row_valid = 1'b1;
        orig_row = row4(60, 70, 80, 90);
        pred_row = row4(61, 72, 83, 94);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_row_ready", row_ready, 0);
            chk("bp_valid", block_valid, 1);
            chk("bp_res", residuals, cur.res);
            @(posedge clk); #1;
        end
        block_ready = 1'b1;
        cur.sat = 0;
        for (int r = 0; r < 4; r++) set_exp(r, row4(8'hFF, 8'hFE, 8'hFD, 8'hFC));
        exp_q.push_back(cur);
        put_row(row4(60, 70, 80, 90), row4(61, 72, 83, 94));
        chk("bp_release_ready", row_ready, 1);
        chk("bp_release_valid", block_valid, 0);
        for (int r = 1; r < 4; r++) put_row(row4(60, 70, 80, 90), row4(61, 72, 83, 94));
        idle(2);

        // back-to-back: 12 rows, 3 blocks
        hs0 = hs_cnt;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            cur.sat = 0;
            for (int i = 0; i < 16; i++) cur.res[i] = 8'(16 * k + i + 1);
            exp_q.push_back(cur);
            for (int r = 0; r < 4; r++)
                put_row(row4(8'(16*k+4*r+1), 8'(16*k+4*r+2), 8'(16*k+4*r+3), 8'(16*k+4*r+4)),
                        row4(0, 0, 0, 0));
        end
        chk("b2b_cycles", cyc - c0, 12);
        idle(2);
        chk("b2b_blocks", hs_cnt - hs0, 3);

        // flush drops partial block and the row presented with it
        for (int r = 0; r < 2; r++) put_row(row4(9, 9, 9, 9), row4(0, 0, 0, 0));
        flush = 1'b1;
        row_valid = 1'b1;
        orig_row = row4(9, 9, 9, 9);
        pred_row = row4(0, 0, 0, 0);
        @(negedge clk);
        chk("flush_row_ready", row_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        row_valid = 1'b0;
        cur.sat = 0;
        for (int r = 0; r < 4; r++) set_exp(r, row4(50, 60, 70, 80));
        exp_q.push_back(cur);
        for (int r = 0; r < 4; r++) put_row(row4(100, 110, 120, 130), row4(50, 50, 50, 50));
        idle(2);

        // async reset between edges after 3 rows
        for (int r = 0; r < 3; r++) put_row(row4(7, 7, 7, 7), row4(0, 0, 0, 0));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", block_valid, 0);
        chk("arst_res", residuals, 0);
        chk("arst_sat", sat_flag, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        cur.sat = 0;
        for (int r = 0; r < 4; r++) set_exp(r, row4(2, 1, 0, 8'hFF));
        exp_q.push_back(cur);
        for (int r = 0; r < 4; r++) put_row(row4(3, 3, 3, 3), row4(1, 2, 3, 4));
        idle(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/residual_gen_4x4.md
Name: residual_gen_4x4

Overview:
- Upstream neighbour of the transform coder.
- Accepts a 4x4 block of original luma samples and the matching intra/inter prediction, one 4-sample row per cycle.
- Computes signed residuals (original − prediction) with saturation and assembles them into a 16-entry parallel block.
- Holds the block under a valid/ready handshake until the transform coder takes it.

Parameters:
- PIX_WIDTH, 8, bit width of original and prediction samples (unsigned).
- RES_WIDTH, 8, bit width of each output residual (two's complement, signed).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous; discards a partially assembled block.
- row_valid  input  1  orig_row/pred_row carry a valid row.
- row_ready  output  1  block can accept a row this cycle.
- orig_row  input  4 x PIX_WIDTH  original samples, column 0..3 of current row.
- pred_row  input  4 x PIX_WIDTH  prediction samples, column 0..3 of current row.
- block_valid  output  1  residuals holds a complete 4x4 block.
- block_ready  input  1  downstream accepts the block.
- residuals  output  16 x RES_WIDTH  signed residuals, index = 4*row + column.
- sat_flag  output  1  at least one of the 16 residuals in the held block was saturated.

Behaviour:
- Reset (reset=0, async): state=FILL, row_cnt=0, block_valid=0, sat_flag=0, all residuals=0; row_ready=1 once reset is released.
- States:
  - FILL: collecting rows; row_cnt 0..3.
  - FULL: complete block held.
- row_ready = !flush && (state==FILL || (state==FULL && block_ready)).
- Row accept = row_valid && row_ready.
- On accept:
  - residuals[4*row_cnt + c] <= sat(orig_row[c] − pred_row[c]) for c=0..3.
  - Difference is computed at PIX_WIDTH+1 bits signed.
  - sat() clamps to [−2^(RES_WIDTH−1), 2^(RES_WIDTH−1)−1], i.e. [−128, 127] at default widths.
  - Row 0 accept: per-block sat accumulator <= OR of this row's saturations (cleared for the new block).
  - Rows 1..3: accumulator |= this row's saturations.
  - row_cnt increments; accepting row 3 wraps row_cnt to 0 and moves state to FULL.
- block_valid = (state==FULL). sat_flag is registered with the block and is stable while block_valid=1.
- Latency: row 3 accepted at edge n → block_valid=1 after edge n; residuals are valid in that same cycle.
- Throughput: one block per 4 cycles when block_ready is held high.
- Output handshake = block_valid && block_ready:
  - Without a simultaneous row accept: state → FILL.
  - With a simultaneous row accept (row 0 of the next block): state → FILL, row_cnt → 1.
  - Entries 0..3 are overwritten with the new row; entries 4..15 keep stale data, which is not observable because block_valid=0.
- In FULL without block_ready: residuals, sat_flag and block_valid hold steady; row_ready=0; no input is consumed.
- flush=1 in FILL: row_cnt → 0, accumulator cleared, any row presented that cycle is dropped (row_ready=0).
- flush=1 in FULL: the held block is kept and block_valid stays 1, but row_ready=0, so a block-out transfer still occurs if block_ready=1.
- Async reset mid-block: the partial block is lost and all outputs return to their reset values immediately.
- row_valid=0 in FILL: no change; rows may arrive with arbitrary gaps.

Test Plan:
- Basic block: 4 rows, orig=100 for all, pred=90,91,92,93 per column → block_valid one cycle after row 3; residuals = 10,9,8,7 repeated per row; sat_flag=0.
- Saturation: row 2 orig={255,0,128,128}, pred={0,255,128,127}, other rows zero diff → residuals[8]=127, [9]=−128, [10]=0, [11]=1; sat_flag=1; the next clean block has sat_flag=0.
- Backpressure: block_ready=0 for 5 cycles after block complete → residuals stable, row_ready=0, incoming rows not consumed; block_ready=1 → handshake, row_ready=1.
- Back-to-back: row_valid and block_ready held 1 for 12 cycles with distinct data → 3 blocks out, block_valid pulses each 4th cycle, no row lost or duplicated.
- Flush: 2 rows accepted, flush=1 with row_valid=1 → row dropped; next 4 rows form a complete correct block.
- Async reset: assert reset=0 after 3 rows and between clock edges → block_valid=0 and residuals=0 immediately; after release, 4 new rows produce a correct block.
